uart_rx_path: RTL and testbench

- Receive path of the debug UART: consumes the asynchronous rx_pin and turns serial 8N1 frames into bytes.
- Bytes are buffered in a small FIFO and presented to the register-side read port that the UART register block polls.
- Sits directly downstream of the board pin and upstream of the UART register read mux; the TX side is out of scope.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_byte_fifo.sv | 54 +++++
 rtl/uart_rx_path.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_path.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the RX FSM state encoding, byte width and the baud divisor function.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; pop_data shows the head with no read latency.
// A push into a full FIFO succeeds only alongside a pop; a pop while empty is ignored.
module uart_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop);
  // Gate the head so the port reads zero out of reset without clearing storage.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_path.sv
// UART receive path: 2-flop sync, 8N1 deframer, FWFT byte FIFO; push 9.5 bit times + 2 cycles after the start edge.
// No backpressure on the line: a byte arriving at a full FIFO is dropped and flags overrun. UART_RX_PARITY_EN selects 8E1.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_pin,
  input  logic                          rd_en,
  output logic [BYTE_W-1:0]             rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun,
  output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  input  logic                          clr_err
);

  localparam int DIV   = uart_div(CLK_FREQ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  logic [1:0]        sync_q;
  logic              rx_s;
  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              push;
  logic              set_fe;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              set_pe;
`endif

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_pin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    set_fe  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    set_pe    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid-start-bit recheck rejects short glitches on the line.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shift_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          if (!rx_s)          set_fe = 1'b1;
          else if (par_bad_q) set_pe = 1'b1;
          else                push   = 1'b1;
`else
          if (rx_s) push   = 1'b1;
          else      set_fe = 1'b1;
`endif
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      overrun    <= (push & full & ~rd_en) | (overrun & ~clr_err);
      frame_err  <= set_fe | (frame_err & ~clr_err);
`ifdef UART_RX_PARITY_EN
      parity_err <= set_pe | (parity_err & ~clr_err);
`endif
    end
  end

  uart_byte_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_q),
    .pop       (rd_en),
    .pop_data  (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

endmodule

// File: tb/tb_uart_rx_path.sv
// Scoreboard bench for uart_rx_path at a scaled line rate of 16 clocks per bit.
// Stimulus queues expected bytes; a monitor pops the FIFO and compares.
module tb_uart_rx_path;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int DIV      = 16;
  localparam int DEPTH    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic       clr_err = 1'b0;
  logic       mon_rd = 1'b0;
  logic       stim_rd = 1'b0;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full, overrun, frame_err;
  logic [4:0] count;

  int         tests = 0;
  int         fails = 0;
  int         lat;
  bit         drain = 1'b0;
  logic [7:0] exp_q [$];

  assign rd_en = mon_rd | stim_rd;

  always #5 clk = ~clk;

  uart_rx_path #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_pin    (rx_pin),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_pin = bits[i];
      repeat (DIV) @(negedge clk);
    end
    rx_pin = 1'b1;
    repeat (2*DIV) @(negedge clk);
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    drain = 1'b1;
    while ((!empty || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bytes_outstanding", exp_q.size(), 0);
    drain = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: whenever draining and a byte is at the head, compare and pop it.
  initial begin
    forever begin
      @(negedge clk);
      mon_rd = 1'b0;
      if (drain && !rst && !empty) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got 0x%02h, none expected", rd_data);
        end else begin
          chk("rd_data", rd_data, exp_q.pop_front());
        end
        mon_rd = 1'b1;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte; empty falls 9.5 bits + 2 sync cycles + 1 cycle after the edge.
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        lat = 0;
        while (empty && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("latency", lat, 155);
    chk("single_count", count, 1);
    chk("single_full", full, 0);
    drain_all();
    chk("single_empty_after_pop", empty, 1);
    chk("single_count_after_pop", count, 0);

    // Glitch shorter than half a bit.
    rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    rx_pin = 1'b1;
    repeat (3*DIV) @(negedge clk);
    chk("glitch_empty", empty, 1);
    chk("glitch_frame_err", frame_err, 0);
    chk("glitch_overrun", overrun, 0);

    // Overflow: 17 bytes, the last one is lost.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      if (i == 15) begin
        chk("ovf_full_at_16", full, 1);
        chk("ovf_count_at_16", count, 16);
        chk("ovf_overrun_at_16", overrun, 0);
      end
    end
    chk("ovf_overrun", overrun, 1);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 16);
    drain_all();
    chk("ovf_overrun_held", overrun, 1);
    pulse_clr();
    chk("ovf_overrun_cleared", overrun, 0);

    // Framing error then a good frame.
    drain = 1'b1;
    send_frame(8'h3C, 1'b0);
    chk("fe_flag", frame_err, 1);
    chk("fe_empty", empty, 1);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    drain_all();
    chk("fe_sticky", frame_err, 1);
    pulse_clr();
    chk("fe_cleared", frame_err, 0);

    // Full FIFO with a pop in the same cycle as the next push.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      send_frame(8'h20 + 8'(i), 1'b1);
    end
    chk("cp_full", full, 1);
    exp_q.push_back(8'h30);
    fork
      send_frame(8'h30, 1'b1);
      begin
        repeat (154) @(negedge clk);
        chk("cp_head", rd_data, exp_q.pop_front());
        stim_rd = 1'b1;
        @(negedge clk);
        stim_rd = 1'b0;
        chk("cp_count", count, 16);
        chk("cp_overrun", overrun, 0);
      end
    join
    chk("cp_full_after", full, 1);
    drain_all();

    // Reset in the middle of 0xFF with state built up beforehand.
    send_frame(8'h3C, 1'b0);
    send_frame(8'h11, 1'b1);
    chk("mr_pre_count", count, 1);
    chk("mr_pre_frame_err", frame_err, 1);
    rx_pin = 1'b0;
    repeat (DIV) @(negedge clk);
    rx_pin = 1'b1;
    repeat (4*DIV + DIV/2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_empty", empty, 1);
    chk("mr_full", full, 0);
    chk("mr_count", count, 0);
    chk("mr_rd_data", rd_data, 0);
    chk("mr_overrun", overrun, 0);
    chk("mr_frame_err", frame_err, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6*DIV) @(negedge clk);
    chk("mr_idle_empty", empty, 1);
    drain = 1'b1;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    drain_all();
    chk("mr_frame_err_after", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
